// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operating modes and
// the load/shift sequencing FSM states.
package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADED   = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/shift_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module shift_cnt #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (inc && cnt != W'(MAX))  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with load/shift-count sequencing and done pulse.
// Optional registered parity output under `UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si_r,
  input  logic             si_l,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
`ifdef UNIV_SHIFT_REG_PARITY_EN
  output logic             parity,
`endif
  output logic             busy
);

  state_t           state, st_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             is_shift, is_load, cnt_clr, cnt_inc, done_nxt;

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

  assign is_load  = en && (mode == MODE_LOAD);
  assign is_shift = en && (mode == MODE_SHR || mode == MODE_SHL);

  always_comb begin
    q_nxt    = q;
    st_nxt   = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    done_nxt = 1'b0;
    if (is_load) begin
      q_nxt   = d;
      cnt_clr = 1'b1;
      st_nxt  = ST_LOADED;
    end else begin
      if (is_shift)
        q_nxt = (mode == MODE_SHR) ? {si_r, q[WIDTH-1:1]} : {q[WIDTH-2:0], si_l};
      case (state)
        ST_IDLE: ;
        ST_LOADED:
          if (is_shift) begin
            cnt_inc = 1'b1;
            st_nxt  = ST_SHIFTING;
          end
        ST_SHIFTING:
          if (is_shift) begin
            cnt_inc = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              st_nxt   = ST_DONE;
              done_nxt = 1'b1;
            end
          end
        // DONE is a single-cycle state no matter what the inputs are
        ST_DONE: st_nxt = ST_IDLE;
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      q     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= st_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
      busy  <= (st_nxt == ST_SHIFTING);
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= ^q_nxt;
  end
`endif

  shift_cnt #(
    .W   (CNT_W),
    .MAX (WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): vector table, hand-written
// reset sequences and randomized traffic against a behavioural model.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst, en, si_r, si_l;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          so_r, so_l, done, busy;
  logic [CW-1:0] cnt;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic          parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model: armed = a load happened and the count has not yet hit W
  logic [W-1:0] m_q;
  int           m_cnt;
  bit           m_armed, m_done;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .si_r   (si_r),
    .si_l   (si_l),
    .q      (q),
    .so_r   (so_r),
    .so_l   (so_l),
    .cnt    (cnt),
    .done   (done),
`ifdef UNIV_SHIFT_REG_PARITY_EN
    .parity (parity),
`endif
    .busy   (busy)
  );

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         si_r, si_l;
    logic [W-1:0] eq;
    int           ecnt;
    logic         edone, ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic [1:0] m, logic [W-1:0] dd, logic r, logic l,
                              logic [W-1:0] eq, int ec, logic ed, logic eb);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.si_r = r; v.si_l = l;
    v.eq = eq; v.ecnt = ec; v.edone = ed; v.ebusy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_cnt = 0; m_armed = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (en) begin
      case (mode)
        2'b11: begin m_q = d; m_cnt = 0; m_armed = 1; end
        2'b01, 2'b10: begin
          m_q = (mode == 2'b01) ? {si_r, m_q[W-1:1]} : {m_q[W-2:0], si_l};
          if (m_armed) begin
            m_cnt++;
            if (m_cnt == W) begin m_armed = 0; m_done = 1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".q"},    64'(q),    64'(m_q));
    chk({tag, ".cnt"},  64'(cnt),  64'(m_cnt));
    chk({tag, ".done"}, 64'(done), 64'(m_done));
    chk({tag, ".busy"}, 64'(busy), 64'(m_armed && m_cnt > 0));
    chk({tag, ".so_r"}, 64'(so_r), 64'(m_q[0]));
    chk({tag, ".so_l"}, 64'(so_l), 64'(m_q[W-1]));
`ifdef UNIV_SHIFT_REG_PARITY_EN
    chk({tag, ".parity"}, 64'(parity), 64'(^m_q));
`endif
  endtask

  // drive away from the edge, clock once, sample 1 time unit later
  task automatic cyc(input logic e, input logic [1:0] m, input logic [W-1:0] dd,
                     input logic r, input logic l);
    en = e; mode = m; d = dd; si_r = r; si_l = l;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    // load A5, eight right shifts: so_r walks 1,0,1,0,0,1,0,1
    tbl.push_back(mk(1, 2'b11, 8'hA5, 0, 0, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h52, 1, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h29, 2, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h14, 3, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h0A, 4, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h05, 5, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h02, 6, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h01, 7, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h00, 8, 1, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 0, 0, 8'h00, 8, 0, 0));
    // IDLE shift moves q, count saturated
    tbl.push_back(mk(1, 2'b10, 8'h00, 0, 1, 8'h01, 8, 0, 0));
    // load 81, three left shifts with si_l=1
    tbl.push_back(mk(1, 2'b11, 8'h81, 0, 1, 8'h81, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 8'h00, 0, 1, 8'h03, 1, 0, 1));
    tbl.push_back(mk(1, 2'b10, 8'h00, 0, 1, 8'h07, 2, 0, 1));
    tbl.push_back(mk(1, 2'b10, 8'h00, 0, 1, 8'h0F, 3, 0, 1));
    // en=0 holds everything, even with a load request
    tbl.push_back(mk(0, 2'b11, 8'hFF, 1, 1, 8'h0F, 3, 0, 1));
    // load 3C, four shifts, reload C3 -> count cleared, no done
    tbl.push_back(mk(1, 2'b11, 8'h3C, 0, 0, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h1E, 1, 0, 1));
    tbl.push_back(mk(1, 2'b10, 8'h00, 0, 0, 8'h3C, 2, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 1, 0, 8'h9E, 3, 0, 1));
    tbl.push_back(mk(1, 2'b01, 8'h00, 0, 0, 8'h4F, 4, 0, 1));
    tbl.push_back(mk(1, 2'b11, 8'hC3, 0, 0, 8'hC3, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 8'h00, 0, 0, 8'hC3, 0, 0, 0));

    // reset dominates a pending load and is seen without a clock edge
    rst = 1; en = 1; mode = 2'b11; d = 8'hFF; si_r = 0; si_l = 0;
    model_reset();
    #1;
    chk("rst_async.q", 64'(q), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold.q", 64'(q), 64'h0);
      chk("rst_hold.cnt", 64'(cnt), 64'h0);
      chk("rst_hold.busy_done", 64'({busy, done}), 64'h0);
    end
    rst = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].si_r, tbl[i].si_l);
      chk($sformatf("vec%0d.q", i),    64'(q),    64'(tbl[i].eq));
      chk($sformatf("vec%0d.cnt", i),  64'(cnt),  64'(tbl[i].ecnt));
      chk($sformatf("vec%0d.done", i), 64'(done), 64'(tbl[i].edone));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(tbl[i].ebusy));
      chk($sformatf("vec%0d.so_r", i), 64'(so_r), 64'(tbl[i].eq[0]));
      chk($sformatf("vec%0d.so_l", i), 64'(so_l), 64'(tbl[i].eq[W-1]));
    end

    // reset pulse in the middle of a shift sequence aborts it for good
    cyc(1, 2'b11, 8'h5A, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 2'b01, 8'h00, 1, 0);
    chk_model("pre_abort");
    #2 rst = 1;
    #1;
    chk("abort.q", 64'(q), 64'h0);
    chk("abort.cnt", 64'(cnt), 64'h0);
    chk("abort.busy", 64'(busy), 64'h0);
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'b01, 8'h00, 1, 0);
      chk_model("post_abort");
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    cyc(1, 2'b11, 8'h07, 0, 0);
    chk("par_load.parity", 64'(parity), 64'h1);
    cyc(1, 2'b01, 8'h00, 0, 0);
    chk("par_shr.q", 64'(q), 64'h03);
    chk("par_shr.parity", 64'(parity), 64'h0);
`endif

    // randomized traffic, shifts favoured so full sequences complete
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] m;
      r = $urandom_range(0, 19);
      m = (r == 0) ? 2'b11 : (r < 3) ? 2'b00 : (r < 11) ? 2'b01 : 2'b10;
      cyc(($urandom_range(0, 9) != 0), m, W'($urandom), 1'($urandom), 1'($urandom));
      chk_model("rand");
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        #1;
        model_reset();
        chk_model("rand_rst");
        rst = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
